// File: rtl/t07_esp_qspi_rx_if.sv
// Bus between the ESP32 quad-SPI receive front end and its MMIO consumer.
// The master drives the ESP32 pins and the pop/clear strobes; the slave returns FIFO status.
interface t07_esp_qspi_rx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          esp_sclk_i;
  logic          esp_cs_n_i;
  logic [3:0]    esp_data_i;
  logic          rd_en_i;
  logic          err_clr_i;
  logic [31:0]   data_o;
  logic          valid_o;
  logic [CW-1:0] count_o;
  logic          busy_o;
  logic          overflow_o;
  logic          frame_err_o;

  modport master (
    output esp_sclk_i, esp_cs_n_i, esp_data_i, rd_en_i, err_clr_i,
    input  data_o, valid_o, count_o, busy_o, overflow_o, frame_err_o
  );

  modport slave (
    input  esp_sclk_i, esp_cs_n_i, esp_data_i, rd_en_i, err_clr_i,
    output data_o, valid_o, count_o, busy_o, overflow_o, frame_err_o
  );
endinterface

// File: rtl/t07_esp_qspi_rx.sv
// ESP32 quad-SPI receive front end: synchronizes the pins, assembles 32-bit words
// MSB-nibble first and buffers them in a show-ahead FIFO for MMIO.
module t07_esp_qspi_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  t07_esp_qspi_rx_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2
  } state_t;

  state_t state_r, state_nx;

  logic [SYNC_STAGES-1:0]      sclk_sync_r;
  logic [SYNC_STAGES-1:0]      cs_sync_r;
  logic [SYNC_STAGES-1:0][3:0] data_sync_r;
  logic                        sclk_q_r;
  logic                        sclk_s, cs_s, rise_s;
  logic [3:0]                  data_s;

  logic [27:0]   shift_reg_r;
  logic [2:0]    nib_cnt_r;
  logic [31:0]   word_s;
  logic          shift_en_s, push_s, clr_cnt_s, ferr_set_s;

  logic [31:0]   mem_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s, empty_s, pop_s, wr_ok_s, ovf_set_s;
  logic          overflow_r, frame_err_r;

  // Pin synchronizers plus a delayed sclk copy for rise detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_r <= '0;
      cs_sync_r   <= '0;
      data_sync_r <= '0;
      sclk_q_r    <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.esp_sclk_i};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.esp_cs_n_i};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], bus.esp_data_i};
      sclk_q_r    <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s   = cs_sync_r[SYNC_STAGES-1];
  assign data_s = data_sync_r[SYNC_STAGES-1];
  assign rise_s = sclk_s & ~sclk_q_r;
  assign word_s = {shift_reg_r, data_s};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= WAIT_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state and datapath strobes; a rise in the same cycle as cs_n high is dropped
  always_comb begin
    state_nx   = state_r;
    shift_en_s = 1'b0;
    push_s     = 1'b0;
    clr_cnt_s  = 1'b0;
    ferr_set_s = 1'b0;
    case (state_r)
      WAIT_IDLE: begin
        if (cs_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = WAIT_IDLE;
        end
      end
      IDLE: begin
        if (!cs_s) begin
          state_nx  = RECV;
          clr_cnt_s = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      RECV: begin
        if (cs_s) begin
          state_nx   = IDLE;
          ferr_set_s = (nib_cnt_r != 3'd0);
        end else if (rise_s) begin
          state_nx   = RECV;
          shift_en_s = 1'b1;
          push_s     = (nib_cnt_r == 3'd7);
        end else begin
          state_nx = RECV;
        end
      end
      default: begin
        state_nx = WAIT_IDLE;
      end
    endcase
  end

  // Nibble shift register; the counter wraps naturally after the eighth nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg_r <= 28'd0;
      nib_cnt_r   <= 3'd0;
    end else if (clr_cnt_s) begin
      nib_cnt_r <= 3'd0;
    end else if (shift_en_s) begin
      shift_reg_r <= word_s[27:0];
      nib_cnt_r   <= nib_cnt_r + 3'd1;
    end
  end

  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign pop_s     = bus.rd_en_i & ~empty_s;
  assign wr_ok_s   = push_s & (~full_s | pop_s);
  assign ovf_set_s = push_s & full_s & ~pop_s;

  // FIFO storage; contents are only observable through the valid-gated head
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= word_s;
    end
  end

  // FIFO pointers, occupancy and sticky flags (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
      case ({wr_ok_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      overflow_r  <= ovf_set_s  | (overflow_r  & ~bus.err_clr_i);
      frame_err_r <= ferr_set_s | (frame_err_r & ~bus.err_clr_i);
    end
  end

  assign bus.valid_o     = (count_r != CW'(0));
  assign bus.data_o      = bus.valid_o ? mem_r[rd_ptr_r[AW-1:0]] : 32'd0;
  assign bus.count_o     = count_r;
  assign bus.busy_o      = (state_r == RECV);
  assign bus.overflow_o  = overflow_r;
  assign bus.frame_err_o = frame_err_r;
endmodule

// File: tb/tb_t07_esp_qspi_rx.sv
// Directed bench for t07_esp_qspi_rx: drives ESP32 pin waveforms on the falling clk edge
// and compares FIFO outputs against hand-computed values.
module tb_t07_esp_qspi_rx;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  t07_esp_qspi_rx_if #(.FIFO_DEPTH(4)) bus ();

  t07_esp_qspi_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // side: 0 none, 1 rd_en on the push cycle, 2 err_clr on the push cycle
  task automatic nib(input logic [3:0] n, input int side);
    bus.esp_data_i = n;
    tick(3);
    bus.esp_sclk_i = 1'b1;
    tick(2);
    if (side == 1) bus.rd_en_i = 1'b1;
    if (side == 2) bus.err_clr_i = 1'b1;
    tick(1);
    bus.rd_en_i   = 1'b0;
    bus.err_clr_i = 1'b0;
    tick(1);
    bus.esp_sclk_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int side);
    for (int i = 0; i < 8; i++) begin
      nib(w[31-4*i -: 4], (i == 7) ? side : 0);
    end
  endtask

  task automatic cs_lo();
    bus.esp_cs_n_i = 1'b0;
    tick(4);
  endtask

  task automatic cs_hi();
    bus.esp_cs_n_i = 1'b1;
    tick(6);
  endtask

  task automatic pop();
    bus.rd_en_i = 1'b1;
    tick(1);
    bus.rd_en_i = 1'b0;
    tick(1);
  endtask

  task automatic clr();
    bus.err_clr_i = 1'b1;
    tick(1);
    bus.err_clr_i = 1'b0;
    tick(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.esp_sclk_i = 1'b0;
    bus.esp_cs_n_i = 1'b1;
    bus.esp_data_i = 4'd0;
    bus.rd_en_i    = 1'b0;
    bus.err_clr_i  = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_data", bus.data_o, 32'd0);
    check("rst_count", 32'(bus.count_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_ovf", 32'(bus.overflow_o), 32'd0);
    check("rst_ferr", 32'(bus.frame_err_o), 32'd0);
    tick(4);

    // single word
    cs_lo();
    check("t1_busy", 32'(bus.busy_o), 32'd1);
    send_word(32'h12345678, 0);
    cs_hi();
    check("t1_busy_end", 32'(bus.busy_o), 32'd0);
    check("t1_valid", 32'(bus.valid_o), 32'd1);
    check("t1_data", bus.data_o, 32'h12345678);
    check("t1_count", 32'(bus.count_o), 32'd1);
    check("t1_ovf", 32'(bus.overflow_o), 32'd0);
    check("t1_ferr", 32'(bus.frame_err_o), 32'd0);
    pop();
    check("t1_valid_pop", 32'(bus.valid_o), 32'd0);

    // five words into a four-deep FIFO
    cs_lo();
    for (int i = 0; i < 5; i++) send_word(32'hA0000000 + 32'(i), 0);
    cs_hi();
    check("t2_count", 32'(bus.count_o), 32'd4);
    check("t2_ovf", 32'(bus.overflow_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t2_data", bus.data_o, 32'hA0000000 + 32'(i));
      pop();
    end
    check("t2_valid_end", 32'(bus.valid_o), 32'd0);
    clr();
    check("t2_ovf_clr", 32'(bus.overflow_o), 32'd0);

    // push coincides with pop while full
    cs_lo();
    for (int i = 0; i < 4; i++) send_word(32'hB0000000 + 32'(i), 0);
    send_word(32'hC0000004, 1);
    cs_hi();
    check("t3_count", 32'(bus.count_o), 32'd4);
    check("t3_ovf", 32'(bus.overflow_o), 32'd0);
    check("t3_d0", bus.data_o, 32'hB0000001); pop();
    check("t3_d1", bus.data_o, 32'hB0000002); pop();
    check("t3_d2", bus.data_o, 32'hB0000003); pop();
    check("t3_d3", bus.data_o, 32'hC0000004); pop();
    check("t3_empty", 32'(bus.count_o), 32'd0);

    // partial frame then a good frame
    cs_lo();
    nib(4'h1, 0); nib(4'h2, 0); nib(4'h3, 0);
    cs_hi();
    check("t4_ferr", 32'(bus.frame_err_o), 32'd1);
    check("t4_count", 32'(bus.count_o), 32'd0);
    cs_lo();
    send_word(32'hDEADBEEF, 0);
    cs_hi();
    check("t4_data", bus.data_o, 32'hDEADBEEF);
    check("t4_count2", 32'(bus.count_o), 32'd1);
    clr();
    check("t4_ferr_clr", 32'(bus.frame_err_o), 32'd0);
    pop();

    // reset mid-frame must not resynchronize until cs_n goes high
    cs_lo();
    nib(4'h1, 0); nib(4'h2, 0); nib(4'h3, 0); nib(4'h4, 0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    nib(4'h5, 0); nib(4'h6, 0); nib(4'h7, 0); nib(4'h8, 0);
    check("t5_count", 32'(bus.count_o), 32'd0);
    check("t5_valid", 32'(bus.valid_o), 32'd0);
    check("t5_busy", 32'(bus.busy_o), 32'd0);
    check("t5_ferr", 32'(bus.frame_err_o), 32'd0);
    cs_hi();
    cs_lo();
    send_word(32'hCAFEF00D, 0);
    cs_hi();
    check("t5_data", bus.data_o, 32'hCAFEF00D);
    check("t5_count2", 32'(bus.count_o), 32'd1);
    pop();

    // err_clr coincident with an overflow drop; pop while empty
    cs_lo();
    for (int i = 0; i < 4; i++) send_word(32'hE0000000 + 32'(i), 0);
    check("t6_ovf_pre", 32'(bus.overflow_o), 32'd0);
    send_word(32'hE0000004, 2);
    cs_hi();
    check("t6_ovf", 32'(bus.overflow_o), 32'd1);
    check("t6_count", 32'(bus.count_o), 32'd4);
    check("t6_head", bus.data_o, 32'hE0000000);
    for (int i = 0; i < 4; i++) pop();
    pop();
    check("t6_count_empty", 32'(bus.count_o), 32'd0);
    check("t6_valid_empty", 32'(bus.valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
